axi_ram_native_bridge: RTL and testbench
========================================

# axi_ram_native_bridge

AXI4 slave that terminates the 64-bit RAM port leaving the SoC interconnect and converts each burst into single-beat commands on a simple native memory interface (SRAM/DDR-controller style). It is the first stage downstream of the core's RAM master port. It handles one burst at a time, arbitrates between reads and writes, and generates AXI R and B responses.

## Interface

Parameters:
- ID_WIDTH, 5, width of all AXI ID fields
- ADDR_WIDTH, 28, byte-address bits forwarded; native word address is ADDR_WIDTH-3 bits

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_awid/i_awaddr/i_awlen/i_awsize/i_awburst  in  ID_WIDTH/32/8/3/2  AW channel
- i_awvalid in 1, o_awready out 1
- i_wdata/i_wstrb/i_wlast  in  64/8/1  W channel; i_wvalid in 1, o_wready out 1
- o_bid/o_bresp  out  ID_WIDTH/2  B channel; o_bvalid out 1, i_bready in 1
- i_arid/i_araddr/i_arlen/i_arsize/i_arburst  in  ID_WIDTH/32/8/3/2  AR channel
- i_arvalid in 1, o_arready out 1
- o_rid/o_rdata/o_rresp/o_rlast  out  ID_WIDTH/64/2/1  R channel; o_rvalid out 1, i_rready in 1
- o_mem_valid out 1, i_mem_ready in 1  native command handshake
- o_mem_we  out  1  1 = write, 0 = read
- o_mem_addr  out  ADDR_WIDTH-3  64-bit word address
- o_mem_wdata/o_mem_wstrb  out  64/8  write data/byte enables
- i_mem_rvalid/i_mem_rdata  in  1/64  read return, exactly one per accepted read command, in order

## Operation

- FSM states: IDLE, WR_DATA, WR_RESP, RD_CMD, RD_WAIT, RD_DATA. Reset -> IDLE.
- IDLE: if only i_awvalid -> write; only i_arvalid -> read; both -> the direction not granted last (flag `last_wr`, reset 0, so the first tie goes to write). o_awready/o_arready are asserted combinationally in IDLE for the granted channel only; the handshake latches ID, address, len, burst, size and clears the beat counter.
- Address update per beat: FIXED holds; INCR and WRAP (WRAP is treated as INCR) add 1<<size to the byte address. o_mem_addr = addr[ADDR_WIDTH-1:3]; upper bits are dropped. The byte address is 32 bits wide and wraps modulo 2^32.
- WR_DATA: o_mem_valid = i_wvalid, o_mem_we = 1, wdata/wstrb pass through combinationally, o_wready = i_mem_ready. A beat completes on i_wvalid & i_mem_ready. After beat len+1 -> WR_RESP.
- WR_RESP: o_bvalid = 1, o_bid = latched ID, o_bresp = OKAY (or per Configuration). On i_bready -> IDLE.
- RD_CMD: o_mem_valid = 1 (registered), o_mem_we = 0. On i_mem_ready -> RD_WAIT.
- RD_WAIT: on i_mem_rvalid, capture i_mem_rdata into the R register -> RD_DATA. i_mem_rvalid in any other state is ignored.
- RD_DATA: o_rvalid = 1, o_rresp = OKAY, o_rid = latched ID, o_rlast = (beat == len). On i_rready: if last -> IDLE, else advance the address -> RD_CMD.
- Only one native command is outstanding at a time. AW and AR are never both accepted in the same cycle.
- Outputs at reset: every valid and ready output is 0; o_bresp, o_rresp, o_rlast and o_mem_we are 0; data, address and ID outputs are 0.

## Timing

- AW/AR acceptance: same cycle as valid while in IDLE. WR_DATA starts the next cycle.
- Write beat: 0-cycle pass-through. Throughput is 1 beat/cycle if the memory is always ready. B is valid the cycle after the last W handshake.
- Read beat: RD_CMD ≥1 cycle, then memory latency, then R valid the cycle after i_mem_rvalid. Minimum 3 cycles per beat.
- IDLE is re-entered the cycle after the final B or R handshake. A new request is accepted at the earliest one cycle later.
- An asynchronous reset mid-burst forces IDLE. Outstanding memory returns after reset are ignored, because the FSM is in IDLE.

## Configuration

- RAM_BRIDGE_WLAST_CHECK_EN defined:
  - A mismatch between i_wlast and (beat == len) on any W beat sets a sticky error, cleared in IDLE.
  - If the error is set, o_bresp = SLVERR (2'b10).
  - Beat count still governs the burst.
- Undefined: i_wlast is ignored, o_bresp is always OKAY, and no check logic is built.

## Test plan

- Single write at 0x100, wdata 0x1122334455667788, strb 0xFF -> mem addr 0x20, we=1, that data/strb; B: bid matches AW, bresp 0, one cycle after the W handshake.
- INCR read at 0x200, len 3, size 3; memory returns 0xA0..0xA3 with 2-cycle latency -> mem addrs 0x40..0x43 in order; four R beats with data 0xA0..0xA3; rlast only on the 4th; i_rready stalled 5 cycles on beat 2 -> rdata held stable.
- AW and AR asserted in the same cycle out of reset -> write granted first; read granted next; a further tie then goes to write.
- FIXED write, len 1, at 0x300 -> both beats go to word 0x60.
- With RAM_BRIDGE_WLAST_CHECK_EN: len 1 write with wlast on beat 0 -> bresp 2'b10 after 2 beats; without the macro -> bresp 0.
- rst pulsed during RD_WAIT of a len-7 read -> next cycle all valids/readies 0, FSM in IDLE; the late i_mem_rvalid produces no R beat; a following write completes normally.

Source files
------------

// File: rtl/axi_ram_native_bridge_if.sv
// rtl/axi_ram_native_bridge_if.sv - AXI4 slave channels and native memory command port of the RAM bridge
interface axi_ram_native_bridge_if #(
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 28
);
  logic [ID_WIDTH-1:0]   i_awid;
  logic [31:0]           i_awaddr;
  logic [7:0]            i_awlen;
  logic [2:0]            i_awsize;
  logic [1:0]            i_awburst;
  logic                  i_awvalid;
  logic                  o_awready;
  logic [63:0]           i_wdata;
  logic [7:0]            i_wstrb;
  logic                  i_wlast;
  logic                  i_wvalid;
  logic                  o_wready;
  logic [ID_WIDTH-1:0]   o_bid;
  logic [1:0]            o_bresp;
  logic                  o_bvalid;
  logic                  i_bready;
  logic [ID_WIDTH-1:0]   i_arid;
  logic [31:0]           i_araddr;
  logic [7:0]            i_arlen;
  logic [2:0]            i_arsize;
  logic [1:0]            i_arburst;
  logic                  i_arvalid;
  logic                  o_arready;
  logic [ID_WIDTH-1:0]   o_rid;
  logic [63:0]           o_rdata;
  logic [1:0]            o_rresp;
  logic                  o_rlast;
  logic                  o_rvalid;
  logic                  i_rready;
  logic                  o_mem_valid;
  logic                  i_mem_ready;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-4:0] o_mem_addr;
  logic [63:0]           o_mem_wdata;
  logic [7:0]            o_mem_wstrb;
  logic                  i_mem_rvalid;
  logic [63:0]           i_mem_rdata;

  modport slave (
    input  i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid,
    output o_awready,
    input  i_wdata, i_wstrb, i_wlast, i_wvalid,
    output o_wready,
    output o_bid, o_bresp, o_bvalid,
    input  i_bready,
    input  i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arvalid,
    output o_arready,
    output o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
    input  i_rready,
    output o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

  modport master (
    output i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid,
    input  o_awready,
    output i_wdata, i_wstrb, i_wlast, i_wvalid,
    input  o_wready,
    input  o_bid, o_bresp, o_bvalid,
    output i_bready,
    output i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arvalid,
    input  o_arready,
    input  o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
    output i_rready,
    input  o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/axi_ram_native_bridge.sv
// rtl/axi_ram_native_bridge.sv - AXI4 burst to single-beat native memory bridge (option: RAM_BRIDGE_WLAST_CHECK_EN)
module axi_ram_native_bridge #(
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_ram_native_bridge_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_CMD, RD_WAIT, RD_DATA} state_t;

  state_t              state, state_nxt;
  logic                last_wr;
  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [63:0]         rdata_q;
  logic                grant_wr, grant_rd;
  logic                wr_beat, rd_beat, last_beat;
  logic [31:0]         addr_next;
  logic                err_q;

  // On a tie the direction that lost the previous grant wins
  assign grant_wr  = (state == IDLE) && bus.i_awvalid && (!bus.i_arvalid || !last_wr);
  assign grant_rd  = (state == IDLE) && bus.i_arvalid && (!bus.i_awvalid ||  last_wr);
  assign last_beat = (beat_q == len_q);
  assign wr_beat   = (state == WR_DATA) && bus.i_wvalid && bus.i_mem_ready;
  assign rd_beat   = (state == RD_DATA) && bus.i_rready;
  // FIXED holds the address; INCR and WRAP both step by the beat size
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_wr) state_nxt = WR_DATA;
               else if (grant_rd) state_nxt = RD_CMD;
      WR_DATA: if (wr_beat && last_beat) state_nxt = WR_RESP;
      WR_RESP: if (bus.i_bready) state_nxt = IDLE;
      RD_CMD:  if (bus.i_mem_ready) state_nxt = RD_WAIT;
      RD_WAIT: if (bus.i_mem_rvalid) state_nxt = RD_DATA;
      RD_DATA: if (rd_beat) state_nxt = last_beat ? IDLE : RD_CMD;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst context capture, address/beat advance and read data holding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      rdata_q <= '0;
    end else begin
      if (grant_wr) begin
        last_wr <= 1'b1;
        id_q    <= bus.i_awid;
        addr_q  <= bus.i_awaddr;
        len_q   <= bus.i_awlen;
        size_q  <= bus.i_awsize;
        burst_q <= bus.i_awburst;
        beat_q  <= '0;
      end else if (grant_rd) begin
        last_wr <= 1'b0;
        id_q    <= bus.i_arid;
        addr_q  <= bus.i_araddr;
        len_q   <= bus.i_arlen;
        size_q  <= bus.i_arsize;
        burst_q <= bus.i_arburst;
        beat_q  <= '0;
      end else if (wr_beat || (rd_beat && !last_beat)) begin
        addr_q  <= addr_next;
        beat_q  <= beat_q + 8'd1;
      end
      if (state == RD_WAIT && bus.i_mem_rvalid) rdata_q <= bus.i_mem_rdata;
    end
  end

`ifdef RAM_BRIDGE_WLAST_CHECK_EN
  // Sticky wlast-position error for the current write burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        err_q <= 1'b0;
    else if (state == IDLE)                         err_q <= 1'b0;
    else if (wr_beat && (bus.i_wlast != last_beat)) err_q <= 1'b1;
  end
`else
  logic unused_wlast;
  assign unused_wlast = bus.i_wlast;
  assign err_q        = 1'b0;
`endif

  // Channel handshakes and native command drive decoded from state
  always_comb begin
    bus.o_awready   = grant_wr;
    bus.o_arready   = grant_rd;
    bus.o_wready    = 1'b0;
    bus.o_bvalid    = 1'b0;
    bus.o_bid       = id_q;
    bus.o_bresp     = 2'b00;
    bus.o_rvalid    = 1'b0;
    bus.o_rid       = id_q;
    bus.o_rdata     = rdata_q;
    bus.o_rresp     = 2'b00;
    bus.o_rlast     = 1'b0;
    bus.o_mem_valid = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = addr_q[ADDR_WIDTH-1:3];
    bus.o_mem_wdata = '0;
    bus.o_mem_wstrb = '0;
    case (state)
      WR_DATA: begin
        bus.o_mem_valid = bus.i_wvalid;
        bus.o_mem_we    = 1'b1;
        bus.o_mem_wdata = bus.i_wdata;
        bus.o_mem_wstrb = bus.i_wstrb;
        bus.o_wready    = bus.i_mem_ready;
      end
      WR_RESP: begin
        bus.o_bvalid = 1'b1;
        bus.o_bresp  = err_q ? 2'b10 : 2'b00;
      end
      RD_CMD:  bus.o_mem_valid = 1'b1;
      RD_DATA: begin
        bus.o_rvalid = 1'b1;
        bus.o_rlast  = last_beat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_ram_native_bridge.sv
// tb/tb_axi_ram_native_bridge.sv - directed self-checking bench for axi_ram_native_bridge
module tb_axi_ram_native_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi_ram_native_bridge_if #(.ID_WIDTH(5), .ADDR_WIDTH(28)) bus ();

  axi_ram_native_bridge #(.ID_WIDTH(5), .ADDR_WIDTH(28)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_awready"}, bus.o_awready, 0);
    check({tag, "_arready"}, bus.o_arready, 0);
    check({tag, "_wready"}, bus.o_wready, 0);
    check({tag, "_bvalid"}, bus.o_bvalid, 0);
    check({tag, "_rvalid"}, bus.o_rvalid, 0);
    check({tag, "_mem_valid"}, bus.o_mem_valid, 0);
    check({tag, "_mem_we"}, bus.o_mem_we, 0);
  endtask

  task automatic write_burst(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int step, input bit tie, input bit gap,
                             input int wlast_beat, input logic [63:0] dbase, input logic [1:0] exp_bresp);
    logic [31:0] a;
    @(negedge clk);
    bus.i_awid = id; bus.i_awaddr = addr; bus.i_awlen = len;
    bus.i_awsize = 3'd3; bus.i_awburst = burst; bus.i_awvalid = 1'b1;
    if (tie) begin
      bus.i_arid = 5'h1f; bus.i_araddr = 32'h0; bus.i_arlen = 8'd0;
      bus.i_arsize = 3'd3; bus.i_arburst = 2'b01; bus.i_arvalid = 1'b1;
    end
    #1;
    check("aw_ready", bus.o_awready, 1);
    check("aw_tie_ar_blocked", bus.o_arready, 0);
    @(negedge clk);
    bus.i_awvalid = 1'b0; bus.i_arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 32'(b * step);
      bus.i_wvalid = 1'b1; bus.i_wdata = dbase + 64'(b);
      bus.i_wstrb = 8'hff >> b; bus.i_wlast = (b == wlast_beat);
      if (gap && b == 0) begin
        bus.i_mem_ready = 1'b0;
        #1;
        check("w_gap_mem_valid", bus.o_mem_valid, 1);
        check("w_gap_wready", bus.o_wready, 0);
        @(negedge clk);
      end
      bus.i_mem_ready = 1'b1;
      #1;
      check("w_mem_valid", bus.o_mem_valid, 1);
      check("w_mem_we", bus.o_mem_we, 1);
      check("w_mem_addr", bus.o_mem_addr, a[27:3]);
      check("w_mem_wdata", bus.o_mem_wdata, dbase + 64'(b));
      check("w_mem_wstrb", bus.o_mem_wstrb, 8'hff >> b);
      check("w_wready", bus.o_wready, 1);
      @(negedge clk);
    end
    bus.i_wvalid = 1'b0; bus.i_mem_ready = 1'b0; bus.i_wlast = 1'b0;
    #1;
    check("b_valid", bus.o_bvalid, 1);
    check("b_id", bus.o_bid, id);
    check("b_resp", bus.o_bresp, exp_bresp);
    check("b_mem_valid", bus.o_mem_valid, 0);
    bus.i_bready = 1'b1;
    @(negedge clk);
    bus.i_bready = 1'b0;
    #1;
    check("b_done", bus.o_bvalid, 0);
  endtask

  task automatic read_burst(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int step, input bit tie, input logic [63:0] dbase,
                            input int stall_beat, input int stall_n);
    logic [31:0] a;
    @(negedge clk);
    bus.i_arid = id; bus.i_araddr = addr; bus.i_arlen = len;
    bus.i_arsize = 3'd3; bus.i_arburst = 2'b01; bus.i_arvalid = 1'b1;
    if (tie) begin
      bus.i_awid = 5'h1e; bus.i_awaddr = 32'h0; bus.i_awlen = 8'd0;
      bus.i_awsize = 3'd3; bus.i_awburst = 2'b01; bus.i_awvalid = 1'b1;
    end
    #1;
    check("ar_ready", bus.o_arready, 1);
    check("ar_tie_aw_blocked", bus.o_awready, 0);
    @(negedge clk);
    bus.i_arvalid = 1'b0; bus.i_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 32'(b * step);
      bus.i_mem_ready = 1'b1;
      #1;
      check("r_cmd_valid", bus.o_mem_valid, 1);
      check("r_cmd_we", bus.o_mem_we, 0);
      check("r_cmd_addr", bus.o_mem_addr, a[27:3]);
      @(negedge clk);
      bus.i_mem_ready = 1'b0;
      #1;
      check("r_wait_mem_valid", bus.o_mem_valid, 0);
      @(negedge clk);
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = dbase + 64'(b);
      @(negedge clk);
      bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = 64'h0;
      #1;
      check("r_valid", bus.o_rvalid, 1);
      check("r_data", bus.o_rdata, dbase + 64'(b));
      check("r_id", bus.o_rid, id);
      check("r_resp", bus.o_rresp, 0);
      check("r_last", bus.o_rlast, b == int'(len));
      if (b == stall_beat) begin
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clk);
          #1;
          check("r_stall_valid", bus.o_rvalid, 1);
          check("r_stall_data", bus.o_rdata, dbase + 64'(b));
        end
      end
      bus.i_rready = 1'b1;
      @(negedge clk);
      bus.i_rready = 1'b0;
    end
    #1;
    check("r_done", bus.o_rvalid, 0);
  endtask

  initial begin
    bus.i_awid = '0; bus.i_awaddr = '0; bus.i_awlen = '0; bus.i_awsize = '0;
    bus.i_awburst = '0; bus.i_awvalid = 1'b0;
    bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wlast = 1'b0; bus.i_wvalid = 1'b0;
    bus.i_bready = 1'b0;
    bus.i_arid = '0; bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arsize = '0;
    bus.i_arburst = '0; bus.i_arvalid = 1'b0;
    bus.i_rready = 1'b0;
    bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;

    repeat (3) @(negedge clk);
    #1;
    idle_outputs("reset");
    check("reset_bresp", bus.o_bresp, 0);
    check("reset_rresp", bus.o_rresp, 0);
    check("reset_rlast", bus.o_rlast, 0);
    check("reset_mem_addr", bus.o_mem_addr, 0);
    check("reset_rdata", bus.o_rdata, 0);
    check("reset_bid", bus.o_bid, 0);
    check("reset_mem_wdata", bus.o_mem_wdata, 0);
    rst = 1'b0;

    // First tie out of reset goes to write, the next to read, then write again
    write_burst(5'h03, 32'h0000_0100, 8'd0, 2'b01, 8, 1'b1, 1'b0, 0, 64'h1122_3344_5566_7788, 2'b00);
    read_burst(5'h11, 32'h0000_0200, 8'd3, 8, 1'b1, 64'h00a0, 2, 5);
    write_burst(5'h07, 32'h0000_0300, 8'd1, 2'b00, 0, 1'b1, 1'b1, 1, 64'hdead_0000, 2'b00);

    // Upper byte-address bits are dropped; the byte address wraps modulo 2^32
    write_burst(5'h02, 32'hf000_0108, 8'd0, 2'b01, 8, 1'b0, 1'b0, 0, 64'h5a5a, 2'b00);
    read_burst(5'h04, 32'hffff_fff8, 8'd1, 8, 1'b0, 64'h00b0, -1, 0);

    // Early wlast: flagged only when the check is built; next burst starts clean
`ifdef RAM_BRIDGE_WLAST_CHECK_EN
    write_burst(5'h09, 32'h0000_0500, 8'd1, 2'b01, 8, 1'b0, 1'b0, 0, 64'h77, 2'b10);
`else
    write_burst(5'h09, 32'h0000_0500, 8'd1, 2'b01, 8, 1'b0, 1'b0, 0, 64'h77, 2'b00);
`endif
    write_burst(5'h0a, 32'h0000_0508, 8'd0, 2'b01, 8, 1'b0, 1'b0, 0, 64'h88, 2'b00);

    // Reset while waiting on read data of a len-7 burst
    @(negedge clk);
    bus.i_arid = 5'h0c; bus.i_araddr = 32'h0000_0400; bus.i_arlen = 8'd7;
    bus.i_arsize = 3'd3; bus.i_arburst = 2'b01; bus.i_arvalid = 1'b1;
    #1;
    check("rst_ar_ready", bus.o_arready, 1);
    @(negedge clk);
    bus.i_arvalid = 1'b0; bus.i_mem_ready = 1'b1;
    #1;
    check("rst_cmd_valid", bus.o_mem_valid, 1);
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    idle_outputs("rst_async");
    @(negedge clk);
    #1;
    idle_outputs("rst_held");
    rst = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'hbad;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    #1;
    check("rst_late_rvalid", bus.o_rvalid, 0);
    check("rst_late_mem_valid", bus.o_mem_valid, 0);
    @(negedge clk);
    #1;
    check("rst_late_rvalid2", bus.o_rvalid, 0);
    write_burst(5'h15, 32'h0000_0600, 8'd2, 2'b01, 8, 1'b0, 1'b0, 2, 64'hc0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
